mem_port_arbiter: RTL and testbench

//  Shares the single memory_controller_module between the instruction-fetch requester and the

---
 rtl/mem_port_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory controller between instruction fetch and load/store: arbitrates,
// checks alignment, holds the access fields, and extends/returns read data with a done pulse.
module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 3,
  parameter int TIMEOUT      = 15,
  parameter int QUIET        = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [23:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [23:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [23:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_mode,
  output logic        mem_enable,
  input  logic [31:0] mem_rdata,
  input  logic        mem_op_r,
  output logic        busy
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int QW = $clog2(QUIET + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_QUIET, S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        r_state;
  logic [QW-1:0] r_quietCnt;
  logic [TW-1:0] r_waitCnt;
  logic [SW-1:0] r_streak;
  logic [23:0]   r_addr;
  logic          r_we;
  logic [31:0]   r_wdata;
  logic [1:0]    r_mode;
  logic          r_enable;
  logic          r_isData;
  logic          r_unsigned;
  logic          r_busy;
  logic          r_iDone, r_iErr, r_dDone, r_dErr;
  logic [31:0]   r_iRdata, r_dRdata;

  logic          w_streakFull, w_grantData, w_grantFetch;
  logic          w_dataErr, w_fetchErr, w_reqErr;
  logic [31:0]   w_loadData;

  // Data normally wins; a fetch that has watched MAX_D_STREAK data grants in a row gets the next slot.
  assign w_streakFull = (r_streak == SW'(MAX_D_STREAK));
  assign w_grantData  = d_req && !(i_req && w_streakFull);
  assign w_grantFetch = i_req && !w_grantData;

  assign w_dataErr  = (d_size == 2'b11) ||
                      (d_size == 2'b10 && d_addr[0]) ||
                      (d_size == 2'b00 && d_addr[1:0] != 2'b00);
  assign w_fetchErr = (i_addr[1:0] != 2'b00);
  assign w_reqErr   = w_grantData ? w_dataErr : w_fetchErr;

  always_comb begin
    w_loadData = mem_rdata;
    case (r_mode)
      2'b01:   w_loadData = {{24{mem_rdata[7] & ~r_unsigned}}, mem_rdata[7:0]};
      2'b10:   w_loadData = {{16{mem_rdata[15] & ~r_unsigned}}, mem_rdata[15:0]};
      default: w_loadData = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_QUIET;
      r_quietCnt <= '0;
      r_waitCnt  <= '0;
      r_streak   <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_mode     <= '0;
      r_enable   <= 1'b0;
      r_isData   <= 1'b0;
      r_unsigned <= 1'b0;
      r_busy     <= 1'b0;
      r_iDone    <= 1'b0;
      r_iErr     <= 1'b0;
      r_iRdata   <= '0;
      r_dDone    <= 1'b0;
      r_dErr     <= 1'b0;
      r_dRdata   <= '0;
    end else begin
      r_enable <= 1'b0;
      r_iDone  <= 1'b0;
      r_iErr   <= 1'b0;
      r_iRdata <= '0;
      r_dDone  <= 1'b0;
      r_dErr   <= 1'b0;
      r_dRdata <= '0;
      case (r_state)
        S_QUIET: begin
          if (r_quietCnt == QW'(QUIET - 1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_quietCnt <= r_quietCnt + QW'(1);
            r_busy     <= 1'b1;
          end
        end
        S_IDLE: begin
          if (w_grantData || w_grantFetch) begin
            r_busy     <= 1'b1;
            r_isData   <= w_grantData;
            r_unsigned <= d_unsigned;
            if (w_grantData) begin
              r_addr   <= d_addr;
              r_we     <= d_we;
              r_wdata  <= d_wdata;
              r_mode   <= d_size;
              r_streak <= i_req ? r_streak + SW'(1) : '0;
            end else begin
              r_addr   <= i_addr;
              r_we     <= 1'b0;
              r_wdata  <= '0;
              r_mode   <= 2'b00;
              r_streak <= '0;
            end
            // Illegal requests never touch memory and answer on the very next cycle.
            if (w_reqErr) begin
              r_state <= S_RESP;
              r_iDone <= w_grantFetch;
              r_iErr  <= w_grantFetch;
              r_dDone <= w_grantData;
              r_dErr  <= w_grantData;
            end else begin
              r_state  <= S_ISSUE;
              r_enable <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          r_state   <= S_WAIT;
          r_waitCnt <= '0;
        end
        S_WAIT: begin
          if (mem_op_r) begin
            r_state <= S_RESP;
            if (r_isData) begin
              r_dDone  <= 1'b1;
              r_dRdata <= r_we ? '0 : w_loadData;
            end else begin
              r_iDone  <= 1'b1;
              r_iRdata <= mem_rdata;
            end
          end else if (r_waitCnt == TW'(TIMEOUT - 1)) begin
            r_state <= S_RESP;
            r_iDone <= !r_isData;
            r_iErr  <= !r_isData;
            r_dDone <= r_isData;
            r_dErr  <= r_isData;
          end else begin
            r_waitCnt <= r_waitCnt + TW'(1);
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign i_done     = r_iDone;
  assign i_err      = r_iErr;
  assign i_rdata    = r_iRdata;
  assign d_done     = r_dDone;
  assign d_err      = r_dErr;
  assign d_rdata    = r_dRdata;
  assign mem_addr   = r_addr;
  assign mem_we     = r_we;
  assign mem_wdata  = r_wdata;
  assign mem_mode   = r_mode;
  assign mem_enable = r_enable;
  assign busy       = r_busy;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a 5-cycle controller model plus a scoreboard of expected
// completions (port, err, data, latency) consumed as done pulses arrive.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, d_unsigned;
  logic [23:0] i_addr, d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_size;
  logic        i_done, i_err, d_done, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic [23:0] mem_addr;
  logic        mem_we, mem_enable, busy;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_mode;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_op_r = 1'b0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_unsigned(d_unsigned), .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_mode(mem_mode),
    .mem_enable(mem_enable), .mem_rdata(mem_rdata), .mem_op_r(mem_op_r), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          isData;
    bit          err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  // Controller model: byte-wide RAM, op_r exactly five cycles after the enable cycle.
  logic [7:0] ram [0:255] = '{0: 8'h63, 1: 8'he8, 2: 8'h20, 3: 8'h00,
                             4: 8'h78, 5: 8'h56, 6: 8'h34, 7: 8'h12,
                             16: 8'h80, 17: 8'h00, 18: 8'h01, 19: 8'h80,
                             default: 8'h00};
  bit          opRTieLow = 1'b0;
  bit          pending = 1'b0;
  int          delay = 0;
  logic [23:0] mAddr = '0;
  logic [1:0]  mMode = '0;

  function automatic logic [31:0] memRead(input logic [23:0] a, input logic [1:0] m);
    logic [7:0] b;
    b = a[7:0];
    case (m)
      2'b01:   return {24'h0, ram[b]};
      2'b10:   return {16'h0, ram[b + 8'd1], ram[b]};
      default: return {ram[b + 8'd3], ram[b + 8'd2], ram[b + 8'd1], ram[b]};
    endcase
  endfunction

  always @(posedge clk) begin
    mem_op_r <= 1'b0;
    if (pending) begin
      if (delay == 1) begin
        mem_op_r  <= !opRTieLow;
        mem_rdata <= memRead(mAddr, mMode);
        pending   <= 1'b0;
      end else begin
        delay <= delay - 1;
      end
    end
    if (mem_enable) begin
      pending <= 1'b1;
      delay   <= 4;
      mAddr   <= mem_addr;
      mMode   <= mem_mode;
      if (mem_we) begin
        ram[mem_addr[7:0]] = mem_wdata[7:0];
        if (mem_mode != 2'b01) ram[mem_addr[7:0] + 8'd1] = mem_wdata[15:8];
        if (mem_mode == 2'b00) begin
          ram[mem_addr[7:0] + 8'd2] = mem_wdata[23:16];
          ram[mem_addr[7:0] + 8'd3] = mem_wdata[31:24];
        end
      end
    end
  end

  // Protocol watcher: enable width, field stability during an access, exclusive done pulses.
  int          enableCount = 0;
  int          enLong = 0;
  int          holdViol = 0;
  int          dualDone = 0;
  bit          prevEn = 1'b0;
  bit          holdActive = 1'b0;
  logic [58:0] holdFields = '0;

  always @(negedge clk) begin
    if (mem_enable && prevEn) enLong++;
    prevEn = mem_enable;
    if (i_done && d_done) dualDone++;
    if (rst) begin
      holdActive = 1'b0;
    end else if (mem_enable) begin
      enableCount++;
      holdActive = 1'b1;
      holdFields = {mem_addr, mem_we, mem_wdata, mem_mode};
    end else if (holdActive) begin
      if ({mem_addr, mem_we, mem_wdata, mem_mode} !== holdFields) holdViol++;
    end
    if (i_done || d_done) holdActive = 1'b0;
  end

  int          obsCyc, obsEnCyc;
  bit          obsI, obsD, obsIErr, obsDErr;
  logic [31:0] obsIRdata, obsDRdata;
  bit          holdReqs = 1'b0;

  task automatic applyStimulus(input bit fetch, input logic [23:0] fAddr, input bit data,
                               input bit we, input logic [23:0] dAddr, input logic [31:0] wdata,
                               input logic [1:0] size, input bit uns);
    @(negedge clk);
    i_addr = fAddr;
    d_we = we;
    d_addr = dAddr;
    d_wdata = wdata;
    d_size = size;
    d_unsigned = uns;
    i_req = fetch;
    d_req = data;
  endtask

  task automatic waitDone(input int budget);
    obsCyc = -1;
    obsEnCyc = -1;
    obsI = 0; obsD = 0; obsIErr = 0; obsDErr = 0;
    obsIRdata = '0; obsDRdata = '0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (mem_enable && obsEnCyc < 0) obsEnCyc = k;
      if (i_done || d_done) begin
        obsCyc = k;
        obsI = i_done; obsD = d_done;
        obsIErr = i_err; obsDErr = d_err;
        obsIRdata = i_rdata; obsDRdata = d_rdata;
        if (!holdReqs) begin
          if (i_done) i_req = 1'b0;
          if (d_done) d_req = 1'b0;
        end
        break;
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    i_req = 0; d_req = 0; d_we = 0; d_unsigned = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_size = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({i_done, i_err, i_rdata, d_done, d_err, d_rdata, mem_addr, mem_we, mem_wdata, mem_mode,
         mem_enable, busy} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got mem_addr=%h en=%b busy=%b i_done=%b d_done=%b, required all 0",
               mem_addr, mem_enable, busy, i_done, d_done);
    end
    // Fetch held from the release: enable may only appear once the quiet window has passed.
    sb.push_back('{1'b0, 1'b0, 32'h0020e863, 13});
    i_req = 1'b1;
    rst = 1'b0;
    waitDone(40);
    vectors++;
    if (obsEnCyc != 7) begin
      miscompares++;
      $display("[TB] FAIL quiet_window: first enable at %0d, required 7", obsEnCyc);
    end
    e = sb.pop_front();
    vectors++;
    if (obsCyc != e.lat || obsI != 1'b1 || obsD != 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_fetch_timing: done at %0d i/d=%0b%0b, required %0d i/d=10", obsCyc, obsI, obsD, e.lat);
    end
    vectors++;
    if (obsIErr !== e.err || obsIRdata !== e.rdata) begin
      miscompares++;
      $display("[TB] FAIL reset_fetch_data: err=%0b rdata=%h, required err=%0b rdata=%h", obsIErr, obsIRdata, e.err, e.rdata);
    end
  endtask

  task automatic test_fetch();
    logic [23:0] addrs [2] = '{24'h0, 24'h4};
    logic [31:0] words [2] = '{32'h0020e863, 32'h12345678};
    exp_t e;
    for (int n = 0; n < 2; n++) begin
      sb.push_back('{1'b0, 1'b0, words[n], 7});
      applyStimulus(1'b1, addrs[n], 1'b0, 1'b0, 24'h0, 32'h0, 2'b00, 1'b0);
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL idle_busy: busy=%b, required 0", busy);
      end
      waitDone(30);
      vectors++;
      if (obsEnCyc != 1) begin
        miscompares++;
        $display("[TB] FAIL fetch_enable: enable at %0d, required 1", obsEnCyc);
      end
      e = sb.pop_front();
      vectors++;
      if (obsCyc != e.lat || obsI != 1'b1 || obsD != 1'b0) begin
        miscompares++;
        $display("[TB] FAIL fetch_timing: done at %0d i/d=%0b%0b, required %0d i/d=10", obsCyc, obsI, obsD, e.lat);
      end
      vectors++;
      if (obsIErr !== e.err || obsIRdata !== e.rdata) begin
        miscompares++;
        $display("[TB] FAIL fetch_data: err=%0b rdata=%h, required err=%0b rdata=%h", obsIErr, obsIRdata, e.err, e.rdata);
      end
    end
  endtask

  task automatic test_load_ext();
    logic [23:0] addrs [5] = '{24'h10, 24'h10, 24'h12, 24'h12, 24'h10};
    logic [1:0]  sizes [5] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00};
    bit          unss  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] wants [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'h80010080};
    exp_t e;
    for (int n = 0; n < 5; n++) begin
      sb.push_back('{1'b1, 1'b0, wants[n], 7});
      applyStimulus(1'b0, 24'h0, 1'b1, 1'b0, addrs[n], 32'h0, sizes[n], unss[n]);
      waitDone(30);
      e = sb.pop_front();
      vectors++;
      if (obsCyc != e.lat || obsD != 1'b1 || obsI != 1'b0) begin
        miscompares++;
        $display("[TB] FAIL load%0d_timing: done at %0d i/d=%0b%0b, required %0d i/d=01", n, obsCyc, obsI, obsD, e.lat);
      end
      vectors++;
      if (obsDErr !== e.err || obsDRdata !== e.rdata) begin
        miscompares++;
        $display("[TB] FAIL load%0d_data: err=%0b rdata=%h, required err=%0b rdata=%h", n, obsDErr, obsDRdata, e.err, e.rdata);
      end
    end
  endtask

  task automatic test_errors();
    bit          isD   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0]  sizes [4] = '{2'b10, 2'b11, 2'b00, 2'b00};
    logic [23:0] addrs [4] = '{24'h11, 24'h0, 24'h2, 24'h6};
    int          enBefore;
    exp_t        e;
    bit          gotErr;
    logic [31:0] gotData;
    enBefore = enableCount;
    for (int n = 0; n < 4; n++) begin
      sb.push_back('{isD[n], 1'b1, 32'h0, 1});
      applyStimulus(!isD[n], addrs[n], isD[n], 1'b0, addrs[n], 32'hFFFFFFFF, sizes[n], 1'b0);
      waitDone(30);
      e = sb.pop_front();
      gotErr = e.isData ? obsDErr : obsIErr;
      gotData = e.isData ? obsDRdata : obsIRdata;
      vectors++;
      if (obsCyc != e.lat || obsD != e.isData || obsI != !e.isData) begin
        miscompares++;
        $display("[TB] FAIL err%0d_timing: done at %0d i/d=%0b%0b, required %0d data=%0b", n, obsCyc, obsI, obsD, e.lat, e.isData);
      end
      vectors++;
      if (gotErr !== e.err || gotData !== e.rdata) begin
        miscompares++;
        $display("[TB] FAIL err%0d_flag: err=%0b rdata=%h, required err=1 rdata=0", n, gotErr, gotData);
      end
    end
    vectors++;
    if (enableCount != enBefore) begin
      miscompares++;
      $display("[TB] FAIL err_no_enable: %0d enables seen, required 0", enableCount - enBefore);
    end
  endtask

  task automatic test_store_load();
    bit          wes   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [23:0] addrs [6] = '{24'h8, 24'h8, 24'h9, 24'h8, 24'hA, 24'h8};
    logic [31:0] wdats [6] = '{32'hAABBCCDD, 32'h0, 32'h1234565A, 32'h0, 32'h9999BEEF, 32'h0};
    logic [1:0]  sizes [6] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    logic [31:0] wants [6] = '{32'h0, 32'hAABBCCDD, 32'h0, 32'hAABB5ADD, 32'h0, 32'hBEEF5ADD};
    exp_t e;
    for (int n = 0; n < 6; n++) begin
      sb.push_back('{1'b1, 1'b0, wants[n], 7});
      applyStimulus(1'b0, 24'h0, 1'b1, wes[n], addrs[n], wdats[n], sizes[n], 1'b0);
      waitDone(30);
      e = sb.pop_front();
      vectors++;
      if (obsCyc != e.lat || obsD != 1'b1 || obsI != 1'b0) begin
        miscompares++;
        $display("[TB] FAIL sl%0d_timing: done at %0d i/d=%0b%0b, required %0d i/d=01", n, obsCyc, obsI, obsD, e.lat);
      end
      vectors++;
      if (obsDErr !== e.err || obsDRdata !== e.rdata) begin
        miscompares++;
        $display("[TB] FAIL sl%0d_data: err=%0b rdata=%h, required err=%0b rdata=%h", n, obsDErr, obsDRdata, e.err, e.rdata);
      end
    end
    vectors++;
    if (holdViol != 0 || enLong != 0) begin
      miscompares++;
      $display("[TB] FAIL mem_hold: %0d field changes, %0d long enables, required 0 and 0", holdViol, enLong);
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    bit          gotErr;
    logic [31:0] gotData;
    holdReqs = 1'b1;
    applyStimulus(1'b1, 24'h0, 1'b1, 1'b0, 24'h8, 32'h0, 2'b00, 1'b0);
    for (int n = 0; n < 8; n++) begin
      if (n % 4 == 3) sb.push_back('{1'b0, 1'b0, 32'h0020e863, 8});
      else            sb.push_back('{1'b1, 1'b0, 32'hBEEF5ADD, (n == 0) ? 7 : 8});
      waitDone(30);
      e = sb.pop_front();
      gotErr = e.isData ? obsDErr : obsIErr;
      gotData = e.isData ? obsDRdata : obsIRdata;
      vectors++;
      if (obsCyc != e.lat || obsD != e.isData || obsI != !e.isData) begin
        miscompares++;
        $display("[TB] FAIL grant%0d: done at %0d i/d=%0b%0b, required %0d data=%0b", n, obsCyc, obsI, obsD, e.lat, e.isData);
      end
      vectors++;
      if (gotErr !== e.err || gotData !== e.rdata) begin
        miscompares++;
        $display("[TB] FAIL grant%0d_data: err=%0b rdata=%h, required err=0 rdata=%h", n, gotErr, gotData, e.rdata);
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    holdReqs = 1'b0;
    vectors++;
    if (dualDone != 0) begin
      miscompares++;
      $display("[TB] FAIL dual_done: %0d cycles with both dones, required 0", dualDone);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    opRTieLow = 1'b1;
    sb.push_back('{1'b0, 1'b1, 32'h0, 17});
    applyStimulus(1'b1, 24'h0, 1'b0, 1'b0, 24'h0, 32'h0, 2'b00, 1'b0);
    waitDone(40);
    opRTieLow = 1'b0;
    e = sb.pop_front();
    vectors++;
    if (obsCyc != e.lat || obsI != 1'b1 || obsD != 1'b0) begin
      miscompares++;
      $display("[TB] FAIL timeout_timing: done at %0d i/d=%0b%0b, required %0d i/d=10", obsCyc, obsI, obsD, e.lat);
    end
    vectors++;
    if (obsIErr !== e.err || obsIRdata !== e.rdata) begin
      miscompares++;
      $display("[TB] FAIL timeout_flag: err=%0b rdata=%h, required err=1 rdata=0", obsIErr, obsIRdata);
    end
  endtask

  task automatic test_reset_mid_access();
    exp_t e;
    int   earlyDone;
    earlyDone = 0;
    applyStimulus(1'b0, 24'h0, 1'b1, 1'b0, 24'h8, 32'h0, 2'b00, 1'b0);
    repeat (3) begin
      @(negedge clk);
      if (i_done || d_done) earlyDone++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.push_back('{1'b1, 1'b0, 32'hBEEF5ADD, 13});
    waitDone(40);
    vectors++;
    if (obsEnCyc != 7 || earlyDone != 0) begin
      miscompares++;
      $display("[TB] FAIL midreset_quiet: enable at %0d, early dones %0d, required 7 and 0", obsEnCyc, earlyDone);
    end
    e = sb.pop_front();
    vectors++;
    if (obsCyc != e.lat || obsD != 1'b1 || obsI != 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_timing: done at %0d i/d=%0b%0b, required %0d i/d=01", obsCyc, obsI, obsD, e.lat);
    end
    vectors++;
    if (obsDErr !== e.err || obsDRdata !== e.rdata) begin
      miscompares++;
      $display("[TB] FAIL midreset_data: err=%0b rdata=%h, required err=0 rdata=%h", obsDErr, obsDRdata, e.rdata);
    end
  endtask

  initial begin
    $display("[TB] mem_port_arbiter bench starting");
    test_reset();
    test_fetch();
    test_load_ext();
    test_errors();
    test_store_load();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
